// File: rtl/counter_pkg.sv
// Shared types for the counter command sequencer: opcodes, FSM states, default counter width.
package counter_pkg;

    localparam int COUNTER_W = 6;

    typedef enum logic [1:0] {OP_NOP, OP_LOAD, OP_RUN, OP_LOAD_RUN} cmd_op_t;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} seq_state_t;

endpackage

// File: rtl/counter_seq.sv
// Command sequencer driving a loadable up-counter with timed load/enable pulses; optional pause via COUNTER_SEQ_PAUSE_EN.
// Latency: first load/enable one cycle after accept; LOAD_RUN of N steps reports done N+2 cycles after accept.
// Backpressure: cmd_ready is high only in IDLE; a held cmd_valid waits until the current command's done has passed.
module counter_seq
    import counter_pkg::*;
#(
    parameter int WIDTH  = COUNTER_W,
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [WIDTH-1:0]  cmd_data,
    input  logic [STEP_W-1:0] cmd_steps,
`ifdef COUNTER_SEQ_PAUSE_EN
    input  logic              pause,
`endif
    output logic              load,
    output logic [WIDTH-1:0]  data,
    output logic              enable,
    output logic              busy,
    output logic              done
);

    seq_state_t        state_q, state_d;
    cmd_op_t           op_q, op_d;
    logic [STEP_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              load_q, load_d;
    logic              enable_q, enable_d;
    logic              done_q, done_d;
    logic              accept;
    logic              hold_run;

`ifdef COUNTER_SEQ_PAUSE_EN
    assign hold_run = pause;
`else
    assign hold_run = 1'b0;
`endif

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d = cmd_op_t'(cmd_op);
                    case (cmd_op_t'(cmd_op))
                        OP_NOP: state_d = S_DONE;
                        OP_LOAD: begin
                            data_d  = cmd_data;
                            state_d = S_LOAD;
                        end
                        OP_RUN: begin
                            cnt_d   = cmd_steps;
                            state_d = (cmd_steps == '0) ? S_DONE : S_RUN;
                        end
                        OP_LOAD_RUN: begin
                            data_d  = cmd_data;
                            cnt_d   = cmd_steps;
                            state_d = S_LOAD;
                        end
                        default: state_d = S_DONE;
                    endcase
                end
            end
            S_LOAD: begin
                state_d = (op_q == OP_LOAD_RUN && cnt_q != '0) ? S_RUN : S_DONE;
            end
            S_RUN: begin
                // The down-counter only moves on cycles that actually drove enable.
                if (enable_q) begin
                    if (cnt_q == STEP_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q - STEP_W'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        load_d   = (state_d == S_LOAD);
        enable_d = (state_d == S_RUN) && !hold_run;
        done_d   = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_NOP;
            cnt_q    <= '0;
            data_q   <= '0;
            load_q   <= 1'b0;
            enable_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            load_q   <= load_d;
            enable_q <= enable_d;
            done_q   <= done_d;
        end
    end

    assign load   = load_q;
    assign data   = data_q;
    assign enable = enable_q;
    assign done   = done_q;

endmodule

// File: tb/tb_counter_seq.sv
// Directed bench for counter_seq with a behavioural 6-bit loadable counter downstream.
module tb_counter_seq;
    import counter_pkg::*;

    localparam int WIDTH  = COUNTER_W;
    localparam int STEP_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [WIDTH-1:0]  cmd_data;
    logic [STEP_W-1:0] cmd_steps;
    logic              load;
    logic [WIDTH-1:0]  data;
    logic              enable;
    logic              busy;
    logic              done;
`ifdef COUNTER_SEQ_PAUSE_EN
    logic              pause;
`endif

    always #5 clk = ~clk;

    counter_seq #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_steps (cmd_steps),
`ifdef COUNTER_SEQ_PAUSE_EN
        .pause     (pause),
`endif
        .load      (load),
        .data      (data),
        .enable    (enable),
        .busy      (busy),
        .done      (done)
    );

    // Downstream counter the sequencer is meant to drive.
    logic [WIDTH-1:0] ctr;
    int overlap = 0;
    always @(posedge clk) begin
        if (rst)         ctr <= '0;
        else if (load)   ctr <= data;
        else if (enable) ctr <= ctr + 1'b1;
        if (load && enable) overlap <= overlap + 1;
    end

    typedef struct {
        logic       rst;
        logic       vld;
        logic [1:0] op;
        logic [5:0] dat;
        logic [7:0] steps;
        logic       e_load;
        logic       e_en;
        logic       e_done;
        logic       e_busy;
        logic       e_rdy;
        logic [5:0] e_data;
        logic [5:0] e_ctr;
    } vec_t;

    vec_t vecs[$];
    int   nvec = 0;
    int   nerr = 0;

    task automatic add(input logic r, input logic v, input logic [1:0] op, input logic [5:0] d,
                       input logic [7:0] s, input logic ld, input logic en, input logic dn,
                       input logic bs, input logic rd, input logic [5:0] dq, input logic [5:0] cq);
        vec_t x;
        x = '{r, v, op, d, s, ld, en, dn, bs, rd, dq, cq};
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [1:0] op,
                         input logic [5:0] d, input logic [7:0] s);
        rst = r; cmd_valid = v; cmd_op = op; cmd_data = d; cmd_steps = s;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int en, n_acc, done1, acc2, idles, c;
        logic acc, seen_done;
        logic [WIDTH-1:0] start_ctr, exp_ctr;
`ifdef COUNTER_SEQ_PAUSE_EN
        pause = 1'b0;
`endif
        drive(1'b1, 1'b0, OP_NOP, 6'd0, 8'd0);

        // rst vld op dat steps | load en done busy rdy data ctr
        add(1, 0, OP_NOP,      0,  0, 0, 0, 0, 0, 1,  0,  0);
        add(1, 0, OP_NOP,      0,  0, 0, 0, 0, 0, 1,  0,  0);
        add(0, 0, OP_NOP,      0,  0, 0, 0, 0, 0, 1,  0,  0);
        add(0, 1, OP_LOAD,    42,  0, 1, 0, 0, 1, 0, 42,  0);
        add(0, 0, OP_NOP,      0,  0, 0, 0, 1, 1, 0, 42, 42);
        add(0, 0, OP_NOP,      0,  0, 0, 0, 0, 0, 1, 42, 42);
        add(0, 1, OP_LOAD_RUN,60,  7, 1, 0, 0, 1, 0, 60, 42);
        for (int i = 0; i < 7; i++)
            add(0, 0, OP_NOP,  0,  0, 0, 1, 0, 1, 0, 60, 6'(60 + i));
        add(0, 0, OP_NOP,      0,  0, 0, 0, 1, 1, 0, 60,  3);
        add(0, 0, OP_NOP,      0,  0, 0, 0, 0, 0, 1, 60,  3);
        add(0, 1, OP_RUN,      5,  0, 0, 0, 1, 1, 0, 60,  3);
        add(0, 0, OP_NOP,      0,  0, 0, 0, 0, 0, 1, 60,  3);
        add(0, 1, OP_NOP,      9,  4, 0, 0, 1, 1, 0, 60,  3);
        add(0, 0, OP_NOP,      0,  0, 0, 0, 0, 0, 1, 60,  3);

        foreach (vecs[i]) begin
            logic [16:0] act, exp;
            drive(vecs[i].rst, vecs[i].vld, vecs[i].op, vecs[i].dat, vecs[i].steps);
            step();
            act = {load, enable, done, busy, cmd_ready, data, ctr};
            exp = {vecs[i].e_load, vecs[i].e_en, vecs[i].e_done, vecs[i].e_busy,
                   vecs[i].e_rdy, vecs[i].e_data, vecs[i].e_ctr};
            nvec++;
            if (act !== exp) begin
                nerr++;
                $display("FAIL vec%0d: got ld=%b en=%b dn=%b bsy=%b rdy=%b data=%0d ctr=%0d, expected ld=%b en=%b dn=%b bsy=%b rdy=%b data=%0d ctr=%0d",
                         i, load, enable, done, busy, cmd_ready, data, ctr,
                         exp[16], exp[15], exp[14], exp[13], exp[12], exp[11:6], exp[5:0]);
            end
        end

        // Held cmd_valid: RUN 3 then RUN 2 queued behind it.
        drive(1'b0, 1'b1, OP_RUN, 6'd0, 8'd3);
        start_ctr = ctr;
        n_acc = 0; en = 0; done1 = -1; acc2 = -1;
        for (int k = 0; k < 40; k++) begin
            acc = cmd_valid && cmd_ready;
            step();
            if (acc) begin
                n_acc++;
                if (n_acc == 1) cmd_steps = 8'd2;
                else begin
                    cmd_valid = 1'b0;
                    acc2 = k;
                end
            end
            if (enable) en++;
            if (done && done1 < 0) done1 = k;
        end
        exp_ctr = start_ctr + 6'd5;
        chk("held_accepts", n_acc, 2);
        chk("held_enables", en, 5);
        chk("held_second_accept", acc2, done1 + 2);
        chk("held_ctr", int'(ctr), int'(exp_ctr));

        // Reset in the middle of a 20-step RUN, after 5 enables.
        drive(1'b0, 1'b1, OP_RUN, 6'd0, 8'd20);
        step();
        cmd_valid = 1'b0;
        en = enable ? 1 : 0;
        c = 0;
        while (en < 5 && c < 40) begin
            step();
            if (enable) en++;
            c++;
        end
        chk("rst_pre_enables", en, 5);
        rst = 1'b1;
        step();
        chk("rst_enable", int'(enable), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_done", int'(done), 0);
        rst = 1'b0;
        en = 0;
        for (int k = 0; k < 25; k++) begin
            step();
            if (enable || load) en++;
        end
        chk("rst_no_pulses", en, 0);

        // Largest burst must not saturate or wrap the step counter.
        drive(1'b0, 1'b1, OP_RUN, 6'd0, 8'd255);
        step();
        cmd_valid = 1'b0;
        en = enable ? 1 : 0;
        seen_done = 1'b0;
        for (int k = 0; k < 300 && !seen_done; k++) begin
            step();
            if (enable) en++;
            if (done) seen_done = 1'b1;
        end
        chk("max_done", int'(seen_done), 1);
        chk("max_enables", en, 255);

`ifdef COUNTER_SEQ_PAUSE_EN
        // Pause 4 cycles in the middle of a 10-step burst.
        drive(1'b0, 1'b1, OP_RUN, 6'd0, 8'd10);
        step();
        cmd_valid = 1'b0;
        en = enable ? 1 : 0;
        c = 0;
        while (en < 3 && c < 20) begin
            step();
            if (enable) en++;
            c++;
        end
        pause = 1'b1;
        idles = 0;
        seen_done = 1'b0;
        for (int k = 0; k < 60 && !seen_done; k++) begin
            if (k == 4) pause = 1'b0;
            step();
            if (enable) en++;
            if (busy && !enable && !done) idles++;
            if (done) seen_done = 1'b1;
        end
        chk("pause_done", int'(seen_done), 1);
        chk("pause_enables", en, 10);
        chk("pause_idle_cycles", idles, 4);
`endif

        chk("load_enable_overlap", overlap, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
